// File: rtl/sram_responder.sv
// Single-port word SRAM behind an addr_ok/data_ok handshake with a fixed,
// parameterised response latency and at most one request in flight.
module sram_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [3:0]            wen_q;
    logic [31:0]           wdata_q;
    logic                  data_ok_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem_q [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic [DEPTH_LOG2-1:0] addr_idx;
    logic [DEPTH_LOG2-1:0] op_idx_d;
    logic [3:0]            op_wen_d;
    logic [31:0]           op_wdata_d;
    logic                  unused_addr_bits;

    assign addr_ok          = (state_q != WAIT);
    assign accept           = req && addr_ok;
    assign addr_idx         = addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
    assign data_ok          = data_ok_q;
    assign rdata            = rdata_q;

    // With LATENCY==1 the RESP-entry edge is the accept edge itself, so the
    // operation comes straight from the inputs instead of the latched copy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        enter_resp = 1'b0;
        op_idx_d   = idx_q;
        op_wen_d   = wen_q;
        op_wdata_d = wdata_q;
        if (LATENCY == 1) begin
            enter_resp = accept && !reset;
            op_idx_d   = addr_idx;
            op_wen_d   = wen;
            op_wdata_d = wdata;
        end else begin
            enter_resp = (state_q == WAIT) && (cnt_q == 4'd0) && !reset;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wen_q     <= 4'h0;
            wdata_q   <= 32'h0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            data_ok_q <= enter_resp;
            if (enter_resp && (op_wen_d == 4'h0)) begin
                rdata_q <= mem_q[op_idx_d];
            end

            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        idx_q   <= addr_idx;
                        wen_q   <= wen;
                        wdata_q <= wdata;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; contents must survive reset and a cleared RAM would not map to SRAM.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (op_wen_d[i]) begin
                    mem_q[op_idx_d][8*i +: 8] <= op_wdata_d[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: a LATENCY=2 and a LATENCY=1 instance,
// each with an expected-response queue drained by its own monitor.
module tb_sram_responder;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        rst_a, req_a, addr_ok_a, data_ok_a;
    logic [3:0]  wen_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        rst_b, req_b, addr_ok_b, data_ok_b;
    logic [3:0]  wen_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    logic [31:0] last_a = 32'h0;
    logic [31:0] last_b = 32'h0;

    sram_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut_a (
        .clk(clk), .reset(rst_a), .req(req_a), .wen(wen_a), .addr(addr_a),
        .wdata(wdata_a), .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
    );

    sram_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_b (
        .clk(clk), .reset(rst_b), .req(req_b), .wen(wen_b), .addr(addr_b),
        .wdata(wdata_b), .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the LATENCY=2 instance.
    always @(negedge clk) begin
        if (!rst_a) begin
            if (data_ok_a) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_data_ok", 32'(data_ok_a), 32'd0);
                end else begin
                    ea = qa.pop_front();
                    check("a_latency", 32'(cyc), 32'(ea.cyc));
                    check("a_rdata", rdata_a, ea.rdata);
                end
            end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
                ea = qa.pop_front();
                check("a_missing_data_ok", 32'(data_ok_a), 32'd1);
            end
        end
    end

    // Monitor for the LATENCY=1 instance.
    always @(negedge clk) begin
        if (!rst_b) begin
            if (data_ok_b) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_data_ok", 32'(data_ok_b), 32'd0);
                end else begin
                    eb = qb.pop_front();
                    check("b_latency", 32'(cyc), 32'(eb.cyc));
                    check("b_rdata", rdata_b, eb.rdata);
                end
            end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
                eb = qb.pop_front();
                check("b_missing_data_ok", 32'(data_ok_b), 32'd1);
            end
        end
    end

    // Present a request and hold it until addr_ok; exp_rd is only used for reads.
    task automatic issue_a(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                           input logic [31:0] exp_rd);
        int n = 0;
        @(negedge clk);
        req_a = 1'b1; addr_a = a; wen_a = w; wdata_a = d;
        while (!addr_ok_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("a_accept_timeout", 32'(addr_ok_a), 32'd1);
        if (w == 4'h0) last_a = exp_rd;
        qa.push_back('{cyc + 2, last_a});
    endtask

    task automatic idle_a();
        @(negedge clk);
        req_a = 1'b0; wen_a = 4'h0;
    endtask

    task automatic drain_a();
        int n = 0;
        while (qa.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("a_drain", 32'(qa.size()), 32'd0);
        qa.delete();
    endtask

    task automatic issue_b(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                           input logic [31:0] exp_rd);
        @(negedge clk);
        req_b = 1'b1; addr_b = a; wen_b = w; wdata_b = d;
        check("b_addr_ok", 32'(addr_ok_b), 32'd1);
        if (w == 4'h0) last_b = exp_rd;
        qb.push_back('{cyc + 1, last_b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_words [3];
        held_words[0] = 32'hA0A0A0A0;
        held_words[1] = 32'hB1B1B1B1;
        held_words[2] = 32'hC2C2C2C2;

        rst_a = 1'b1; req_a = 1'b0; wen_a = 4'h0; addr_a = 32'h0; wdata_a = 32'h0;
        rst_b = 1'b1; req_b = 1'b0; wen_b = 4'h0; addr_b = 32'h0; wdata_b = 32'h0;
        #1;
        check("rst_data_ok", 32'(data_ok_a), 32'd0);
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_addr_ok", 32'(addr_ok_a), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("post_rst_data_ok", 32'(data_ok_a), 32'd0);
        check("post_rst_rdata", rdata_a, 32'h0);

        // Write then read the same word, plus aliases through addr[1:0] and upper bits.
        issue_a(32'h0000_0010, 4'hF, 32'h12345678, 32'h0);
        issue_a(32'h0000_0010, 4'h0, 32'h0, 32'h12345678);
        issue_a(32'h0000_0013, 4'h0, 32'h0, 32'h12345678);
        issue_a(32'hFFFF_F010, 4'h0, 32'h0, 32'h12345678);
        idle_a();
        drain_a();

        // Byte-masked overwrite.
        issue_a(32'h20, 4'hF, 32'h12345678, 32'h0);
        issue_a(32'h20, 4'b0101, 32'hAABBCCDD, 32'h0);
        issue_a(32'h20, 4'h0, 32'h0, 32'h12BB56DD);
        idle_a();
        drain_a();

        // Preload, then reads with req held high: addr_ok must toggle 1,0,1,0,1.
        issue_a(32'h0, 4'hF, held_words[0], 32'h0);
        issue_a(32'h4, 4'hF, held_words[1], 32'h0);
        issue_a(32'h8, 4'hF, held_words[2], 32'h0);
        idle_a();
        drain_a();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_a = 1'b1; wen_a = 4'h0; addr_a = 32'(((k + 1) / 2) * 4);
            check("held_addr_ok", 32'(addr_ok_a), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                last_a = held_words[k / 2];
                qa.push_back('{cyc + 2, last_a});
            end
        end
        idle_a();
        drain_a();

        // Index wrap: 0x1000 aliases word 0.
        issue_a(32'h1000, 4'hF, 32'hCAFEF00D, 32'h0);
        issue_a(32'h0, 4'h0, 32'h0, 32'hCAFEF00D);
        idle_a();
        drain_a();

        // Reset during WAIT drops the write; memory keeps the older word.
        issue_a(32'h40, 4'hF, 32'h01020304, 32'h0);
        issue_a(32'h40, 4'h0, 32'h0, 32'h01020304);
        idle_a();
        drain_a();
        issue_a(32'h40, 4'hF, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        req_a = 1'b0; wen_a = 4'h0;
        check("wait_addr_ok", 32'(addr_ok_a), 32'd0);
        rst_a = 1'b1;
        qa.delete();
        last_a = 32'h0;
        #1;
        check("async_rst_data_ok", 32'(data_ok_a), 32'd0);
        check("async_rst_rdata", rdata_a, 32'h0);
        check("async_rst_addr_ok", 32'(addr_ok_a), 32'd1);
        @(posedge clk);
        #2;
        check("rst_hold_data_ok", 32'(data_ok_a), 32'd0);
        rst_a = 1'b0;
        check("rst_release_rdata", rdata_a, 32'h0);
        issue_a(32'h40, 4'h0, 32'h0, 32'h01020304);
        idle_a();
        drain_a();

        // LATENCY=1: one request every cycle, one response every cycle.
        issue_b(32'h0, 4'hF, 32'h0000AAAA, 32'h0);
        issue_b(32'h4, 4'hF, 32'h0000BBBB, 32'h0);
        issue_b(32'h0, 4'h0, 32'h0, 32'h0000AAAA);
        issue_b(32'h8, 4'hF, 32'h0000CCCC, 32'h0);
        issue_b(32'h8, 4'h0, 32'h0, 32'h0000CCCC);
        issue_b(32'h4, 4'h0, 32'h0, 32'h0000BBBB);
        @(negedge clk);
        req_b = 1'b0; wen_b = 4'h0;
        begin
            int n = 0;
            while (qb.size() != 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b_drain", 32'(qb.size()), 32'd0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
